// File: rtl/frame_page_flipper_n.sv
// frame_page_flipper_n: N-page frame buffer flipper tracking scaler read page and writer fill page
module frame_page_flipper_n #(
   parameter int NUM_PAGES = 3,
   parameter int ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h2400_0000,
   parameter logic [ADDR_WIDTH-1:0] PAGE_SIZE = 32'h0008_0000,
   parameter int SYNC_STAGES = 2,
   parameter int DROP_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  mode,
   input  logic                  read_vblank,
   input  logic                  write_vblank,
   output logic [ADDR_WIDTH-1:0] addr_read,
   output logic [ADDR_WIDTH-1:0] addr_write,
   output logic [1:0]            page_read,
   output logic [1:0]            page_write,
   output logic                  frame_pending,
   output logic [DROP_WIDTH-1:0] drop_count
);
   logic [SYNC_STAGES-1:0] readSync, writeSync;
   logic readPrev, writePrev, swapRead, swapWrite, effMode, lastMode;
   logic [1:0] rdPage, wrPage, latest;
   logic pending;
   logic [DROP_WIDTH-1:0] dropCount;

   function automatic logic [1:0] lowestFree(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] r;
      r = 2'd0;
      for (int i = NUM_PAGES - 1; i >= 0; i--)
         if (2'(i) != a && 2'(i) != b) r = 2'(i);
      return r;
   endfunction

   assign swapRead = readSync[SYNC_STAGES-1] & ~readPrev;
   assign swapWrite = writeSync[SYNC_STAGES-1] & ~writePrev;
   assign effMode = (NUM_PAGES == 2) ? 1'b0 : mode;
   assign addr_read = BASE_ADDR + ADDR_WIDTH'(rdPage) * PAGE_SIZE;
   assign addr_write = BASE_ADDR + ADDR_WIDTH'(wrPage) * PAGE_SIZE;
   assign page_read = rdPage;
   assign page_write = wrPage;
   assign frame_pending = pending;
   assign drop_count = dropCount;

   // vBlank synchronisers and edge history run regardless of enable so held levels never pulse late
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         readSync <= '0;
         writeSync <= '0;
         readPrev <= 1'b0;
         writePrev <= 1'b0;
      end else begin
         readSync <= {readSync[SYNC_STAGES-2:0], read_vblank};
         writeSync <= {writeSync[SYNC_STAGES-2:0], write_vblank};
         readPrev <= readSync[SYNC_STAGES-1];
         writePrev <= writeSync[SYNC_STAGES-1];
      end

   // page rotation, mode reinitialisation and dropped-frame accounting
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         rdPage <= 2'd0;
         wrPage <= 2'd1;
         latest <= 2'd0;
         pending <= 1'b0;
         dropCount <= '0;
         lastMode <= 1'b0;
      end else if (enable) begin
         if (effMode != lastMode) begin
            lastMode <= effMode;
            rdPage <= 2'd0;
            wrPage <= 2'd1;
            pending <= 1'b0;
         end else if (!effMode) begin
            if (swapWrite) begin
               rdPage <= wrPage;
               wrPage <= rdPage;
            end
         end else if (swapRead && swapWrite) begin
            rdPage <= wrPage;
            wrPage <= lowestFree(wrPage, wrPage);
            pending <= 1'b0;
            if (pending && dropCount != '1) dropCount <= dropCount + DROP_WIDTH'(1);
         end else if (swapWrite) begin
            latest <= wrPage;
            pending <= 1'b1;
            wrPage <= lowestFree(rdPage, wrPage);
            if (pending && dropCount != '1) dropCount <= dropCount + DROP_WIDTH'(1);
         end else if (swapRead && pending) begin
            rdPage <= latest;
            pending <= 1'b0;
         end
      end
endmodule

// File: tb/tb_frame_page_flipper_n.sv
// tb_frame_page_flipper_n: directed bench for the N-page frame buffer flipper
module tb_frame_page_flipper_n;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b1;
   logic mode = 1'b0;
   logic read_vblank = 1'b0;
   logic write_vblank = 1'b0;
   logic [31:0] addr_read, addr_write;
   logic [1:0] page_read, page_write;
   logic frame_pending;
   logic [7:0] drop_count;
   int testCount = 0;
   int failCount = 0;

   frame_page_flipper_n dut (
      .clock(clock), .reset(reset), .enable(enable), .mode(mode),
      .read_vblank(read_vblank), .write_vblank(write_vblank),
      .addr_read(addr_read), .addr_write(addr_write),
      .page_read(page_read), .page_write(page_write),
      .frame_pending(frame_pending), .drop_count(drop_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic pulse(input logic w, input logic r);
      @(negedge clock);
      write_vblank = w;
      read_vblank = r;
      repeat (3) @(posedge clock);
      @(negedge clock);
      write_vblank = 1'b0;
      read_vblank = 1'b0;
      repeat (4) @(posedge clock);
      @(negedge clock);
   endtask

   task automatic doReset(input logic m);
      @(negedge clock);
      #2 reset = 1'b0;
      mode = m;
      write_vblank = 1'b0;
      read_vblank = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   initial begin
      repeat (2) @(negedge clock);
      check("rst_addr_read", addr_read, 32'h2400_0000);
      check("rst_addr_write", addr_write, 32'h2408_0000);
      check("rst_page_read", page_read, 0);
      check("rst_page_write", page_write, 1);
      check("rst_drop", drop_count, 0);
      check("rst_pending", frame_pending, 0);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // mode 0: write swap lands on the third edge
      write_vblank = 1'b1;
      repeat (2) @(posedge clock);
      #1 check("m0_not_yet", page_read, 0);
      @(posedge clock);
      #1 check("m0_page_read", page_read, 1);
      check("m0_page_write", page_write, 0);
      check("m0_addr_read", addr_read, 32'h2408_0000);
      check("m0_addr_write", addr_write, 32'h2400_0000);
      repeat (50) @(posedge clock);
      #1 check("m0_hold_read", page_read, 1);
      check("m0_hold_write", page_write, 0);
      @(negedge clock);
      write_vblank = 1'b0;
      repeat (4) @(negedge clock);
      pulse(1'b0, 1'b1);
      check("m0_rswap_read", page_read, 1);
      check("m0_rswap_write", page_write, 0);
      check("m0_rswap_pend", frame_pending, 0);

      // mode toggle reinitialises pages
      mode = 1'b1;
      @(posedge clock);
      #1 check("toggle_read", page_read, 0);
      check("toggle_write", page_write, 1);
      @(negedge clock);

      // mode 1 write then read
      pulse(1'b1, 1'b0);
      check("m1_w_write", page_write, 2);
      check("m1_w_read", page_read, 0);
      check("m1_w_pend", frame_pending, 1);
      pulse(1'b0, 1'b1);
      check("m1_r_read", page_read, 1);
      check("m1_r_pend", frame_pending, 0);
      check("m1_r_write", page_write, 2);
      check("m1_r_drop", drop_count, 0);
      pulse(1'b0, 1'b1);
      check("m1_repeat_read", page_read, 1);

      // async reset mid-frame
      @(negedge clock);
      write_vblank = 1'b1;
      @(posedge clock);
      #3 reset = 1'b0;
      #1 check("arst_read", page_read, 0);
      check("arst_write", page_write, 1);
      check("arst_addr_write", addr_write, 32'h2408_0000);
      doReset(1'b1);

      // two write swaps without read: one drop
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      check("drop_count", drop_count, 1);
      check("drop_write", page_write, 1);
      check("drop_read", page_read, 0);
      check("drop_pend", frame_pending, 1);
      pulse(1'b0, 1'b1);
      check("drop_latest_read", page_read, 2);
      check("drop_latest_pend", frame_pending, 0);

      // simultaneous swaps
      doReset(1'b1);
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b1);
      check("both_read", page_read, 2);
      check("both_write", page_write, 0);
      check("both_pend", frame_pending, 0);
      check("both_drop", drop_count, 1);
      check("both_addr_read", addr_read, 32'h2410_0000);

      // enable low drops the swap, re-enable mid-level gives no late pulse
      enable = 1'b0;
      write_vblank = 1'b1;
      repeat (4) @(negedge clock);
      enable = 1'b1;
      repeat (5) @(negedge clock);
      check("en_read", page_read, 2);
      check("en_write", page_write, 0);
      check("en_pend", frame_pending, 0);
      write_vblank = 1'b0;
      repeat (4) @(negedge clock);
      pulse(1'b1, 1'b0);
      check("en_after_write", page_write, 1);
      check("en_after_pend", frame_pending, 1);

      // back to mode 0 keeps drop count
      mode = 1'b0;
      @(posedge clock);
      #1 check("back_read", page_read, 0);
      check("back_write", page_write, 1);
      check("back_pend", frame_pending, 0);
      check("back_drop", drop_count, 1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end
endmodule
